// File: rtl/kafa_pkg.sv
// Shared definitions for the coffee machine supply side: escrow state encoding,
// default capacities and timing constants, and strobe bit positions.
package kafa_pkg;

    typedef enum logic [1:0] {
        ESC_EMPTY = 2'd0,
        ESC_HELD  = 2'd1,
        ESC_BUSY  = 2'd2,
        ESC_EJECT = 2'd3
    } escrow_t;

    localparam int DEF_CNT_W        = 8;
    localparam int DEF_CUP_CAP      = 50;
    localparam int DEF_POWDER_CAP   = 100;
    localparam int DEF_WATER_CAP    = 100;
    localparam int DEF_DEBOUNCE_CYC = 1000;
    localparam int DEF_EJECT_CYC    = 100000;
    localparam int DEF_LOW_THR      = 5;

    // The eject timer is fixed at 19 bits, enough for the default pulse length.
    localparam int TMR_W = 19;

    localparam int STB_N  = 5;
    localparam int STB_PG = 0;
    localparam int STB_CP = 1;
    localparam int STB_HW = 2;
    localparam int STB_UL = 3;
    localparam int STB_CR = 4;

endpackage

// File: rtl/kafa_stock_cnt.sv
// Saturating stock counter: counts down on each dispense pulse, reloads to
// capacity on refill, and flags whether any stock remains.
module kafa_stock_cnt #(
    parameter int CNT_W = 8,
    parameter int CAP   = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dec,
    input  logic             refill,
    output logic [CNT_W-1:0] count,
    output logic             avail
);

    logic [CNT_W-1:0] count_n;

    // Refill has priority so a service visit is never undercut by a dispense.
    always_comb begin
        count_n = count;
        if (refill) begin
            count_n = CNT_W'(CAP);
        end else if (dec && (count != '0)) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= CNT_W'(CAP);
            avail <= (CAP != 0);
        end else begin
            count <= count_n;
            avail <= (count_n != '0);
        end
    end

endmodule

// File: rtl/kafa_supply.sv
// Supply-side responder for the coffee controller: coin escrow FSM, coin debounce,
// eject timer and three stock counters. Optional low-stock flag: KAFA_SUPPLY_LOW_WARN_EN.
module kafa_supply
    import kafa_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int CUP_CAP      = DEF_CUP_CAP,
    parameter int POWDER_CAP   = DEF_POWDER_CAP,
    parameter int WATER_CAP    = DEF_WATER_CAP,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int EJECT_CYC    = DEF_EJECT_CYC
`ifdef KAFA_SUPPLY_LOW_WARN_EN
    ,
    parameter int LOW_THR      = DEF_LOW_THR
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic coin_in,
    input  logic refill,
    input  logic plastic_glass,
    input  logic coffee_powder,
    input  logic hot_water,
    input  logic unlock,
    input  logic coin_return,
    output logic coin_avail,
    output logic plastic_glass_avail,
    output logic coffee_powder_avail,
    output logic water_avail,
    output logic coin_eject,
    output logic proto_err
`ifdef KAFA_SUPPLY_LOW_WARN_EN
    ,
    output logic low_stock
`endif
);

    localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             coin_sync1;
    logic             coin_sync2;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_done;
    logic             coin_pulse;

    logic [STB_N-1:0] strobe;
    logic [STB_N-1:0] strobe_q;
    logic [STB_N-1:0] strobe_q2;
    logic             refill_q;
    logic             pg_rise;
    logic             cp_rise;
    logic             hw_rise;
    logic             cr_rise;
    logic             ul_fall;

    escrow_t          state;
    escrow_t          state_n;
    logic             shadow;
    logic             shadow_n;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_n;
    logic             eject_active;
    logic             refuse;
    logic             perr_n;
    logic             coin_avail_n;
    logic             coin_eject_n;

    logic [CNT_W-1:0] cup_count;
    logic [CNT_W-1:0] powder_count;
    logic [CNT_W-1:0] water_count;

    // A coin counts once per continuous high period of the synchronized sensor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coin_sync1 <= 1'b0;
            coin_sync2 <= 1'b0;
            deb_cnt    <= '0;
            deb_done   <= 1'b0;
            coin_pulse <= 1'b0;
        end else begin
            coin_sync1 <= coin_in;
            coin_sync2 <= coin_sync1;
            coin_pulse <= 1'b0;
            if (!coin_sync2) begin
                deb_cnt  <= '0;
                deb_done <= 1'b0;
            end else if (!deb_done) begin
                if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
                    coin_pulse <= 1'b1;
                    deb_done   <= 1'b1;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end
    end

    assign strobe[STB_PG] = plastic_glass;
    assign strobe[STB_CP] = coffee_powder;
    assign strobe[STB_HW] = hot_water;
    assign strobe[STB_UL] = unlock;
    assign strobe[STB_CR] = coin_return;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q  <= '0;
            strobe_q2 <= '0;
            refill_q  <= 1'b0;
        end else begin
            strobe_q  <= strobe;
            strobe_q2 <= strobe_q;
            refill_q  <= refill;
        end
    end

    assign pg_rise = strobe_q[STB_PG] & ~strobe_q2[STB_PG];
    assign cp_rise = strobe_q[STB_CP] & ~strobe_q2[STB_CP];
    assign hw_rise = strobe_q[STB_HW] & ~strobe_q2[STB_HW];
    assign cr_rise = strobe_q[STB_CR] & ~strobe_q2[STB_CR];
    assign ul_fall = strobe_q2[STB_UL] & ~strobe_q[STB_UL];

    assign eject_active = (state == ESC_EJECT) || shadow;

    // The shadow flag lets a refused coin be ejected without disturbing a vend in progress.
    always_comb begin
        state_n = state;
        shadow_n = shadow;
        tmr_n = tmr;
        refuse = 1'b0;
        perr_n = proto_err;

        case (state)
            ESC_EMPTY: begin
                if (coin_pulse) state_n = ESC_HELD;
                if (pg_rise) perr_n = 1'b1;
            end
            ESC_HELD: begin
                refuse = coin_pulse;
                if (cr_rise) state_n = ESC_EJECT;
                else if (pg_rise) state_n = ESC_BUSY;
            end
            ESC_BUSY: begin
                refuse = coin_pulse;
                if (ul_fall) state_n = ESC_EMPTY;
            end
            ESC_EJECT: begin
                state_n = ESC_EJECT;
            end
            default: state_n = ESC_EMPTY;
        endcase

        if ((state_n == ESC_EJECT) && ((state != ESC_EJECT) || coin_pulse)) begin
            tmr_n = '0;
            shadow_n = 1'b0;
        end else if (refuse) begin
            tmr_n = '0;
            shadow_n = 1'b1;
        end else if (eject_active) begin
            if (tmr == TMR_W'(EJECT_CYC - 1)) begin
                shadow_n = 1'b0;
                if (state == ESC_EJECT) state_n = ESC_EMPTY;
            end else begin
                tmr_n = tmr + 1'b1;
            end
        end

        coin_avail_n = (state_n == ESC_HELD);
        coin_eject_n = (state_n == ESC_EJECT) || shadow_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ESC_EMPTY;
            shadow     <= 1'b0;
            tmr        <= '0;
            coin_avail <= 1'b0;
            coin_eject <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_n;
            shadow     <= shadow_n;
            tmr        <= tmr_n;
            coin_avail <= coin_avail_n;
            coin_eject <= coin_eject_n;
            proto_err  <= perr_n;
        end
    end

    kafa_stock_cnt #(.CNT_W(CNT_W), .CAP(CUP_CAP)) u_cup (
        .clk    (clk),
        .reset_n(reset_n),
        .dec    (pg_rise),
        .refill (refill_q),
        .count  (cup_count),
        .avail  (plastic_glass_avail)
    );

    kafa_stock_cnt #(.CNT_W(CNT_W), .CAP(POWDER_CAP)) u_powder (
        .clk    (clk),
        .reset_n(reset_n),
        .dec    (cp_rise),
        .refill (refill_q),
        .count  (powder_count),
        .avail  (coffee_powder_avail)
    );

    kafa_stock_cnt #(.CNT_W(CNT_W), .CAP(WATER_CAP)) u_water (
        .clk    (clk),
        .reset_n(reset_n),
        .dec    (hw_rise),
        .refill (refill_q),
        .count  (water_count),
        .avail  (water_avail)
    );

`ifdef KAFA_SUPPLY_LOW_WARN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            low_stock <= 1'b0;
        end else begin
            low_stock <= (cup_count <= CNT_W'(LOW_THR)) ||
                         (powder_count <= CNT_W'(LOW_THR)) ||
                         (water_count <= CNT_W'(LOW_THR));
        end
    end
`endif

endmodule
